vector_lsu: RTL and testbench
=============================

Name: vector_lsu

Overview:
- Vector load/store unit; the responder to the instruction decoder's start/rw/stride_enable/mask_enable command and the source of its done handshake.
- Per command, it walks VLEN elements between data memory and the selected vector register.
- Supports unit-stride, strided and masked access modes.
- Sits between the decoder, the vector register file (read/write port indexed by elem_idx) and the single-port data memory.

Parameters:
- VLEN, 8, elements per vector; power of two, 2 to 64.
- DW, 8, element and memory data width.
- AW, 8, memory address width.
- IW, 3, elem_idx width; equals log2(VLEN).

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  command strobe from decoder; sampled only in IDLE.
- rw  input  1  0 = load (memory to vreg), 1 = store (vreg to memory).
- stride_enable  input  1  1 = address step is stride; 0 = step is 1.
- mask_enable  input  1  1 = element i is accessed only if mask[i] = 1.
- base  input  AW  start address (scalar register rx value).
- stride  input  AW  address step (scalar register ry value).
- mask  input  VLEN  element mask (mask register value).
- vreg_rdata  input  DW  vreg read data at elem_idx; combinational read.
- mem_rdata  input  DW  memory read data; valid one cycle after mem_re.
- elem_idx  output  IW  current element index.
- vreg_we  output  1  vreg write strobe.
- vreg_wdata  output  DW  vreg write data.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_we  output  1  memory write strobe.
- mem_re  output  1  memory read strobe.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, RUN, CAPT, DONE. Outputs are Moore, decoded from state and registers.
- Reset (reset = 0, asynchronous): state = IDLE; idx = 0; addr = 0; latched rw/stride/mask/flags = 0. All strobes, busy and done = 0. Applies mid-operation: any in-flight access is abandoned with no further strobes and no done.
- IDLE, posedge with start = 1: latch rw, stride_enable, mask_enable, base, stride, mask; idx = 0; addr = base; go to RUN.
- IDLE, start = 0: stay in IDLE.
- start while not IDLE is ignored; no queuing.
- active = ~mask_enable_l | mask_l[idx].
- RUN, store and active: mem_we = 1; mem_addr = addr; mem_wdata = vreg_rdata; then advance.
- RUN, load and active: mem_re = 1; mem_addr = addr; go to CAPT.
- CAPT: vreg_we = 1; vreg_wdata = mem_rdata; elem_idx unchanged; then advance.
- RUN, inactive element: no strobes; one skip cycle; advance.
- Advance: addr += (stride_enable_l ? stride_l : 1), modulo 2^AW (wraps silently).
  - The address steps even on masked-off elements, so element i always maps to base + i*step.
  - If idx = VLEN-1, go to DONE; else idx += 1 and return to RUN.
- stride_enable and mask_enable both set: both are honoured.
- DONE: done = 1 for exactly one cycle; then IDLE.
  - done is high for a full clock period, so a negedge-sampling decoder sees it once.
  - A start in the DONE cycle is ignored.
- elem_idx = idx whenever busy, 0 in IDLE.
- mem_addr = 0 when no strobe is active.
- Latency from the start-sampling edge, with s = active elements and u = inactive elements:
  - Store: VLEN cycles of RUN, then DONE; done is asserted in cycle VLEN+1.
  - Load: 2s + u cycles, then DONE.
- All elements masked off: VLEN skip cycles, no strobes, then done.

Test Plan:
- Unit-stride store: base = 0x10, mask_enable = 0, vreg elements = 0xA0..0xA7 -> mem_we in cycles 1-8 at addresses 0x10..0x17 with data 0xA0..0xA7; done only in cycle 9; busy high in cycles 1-9.
- Strided load: base = 0x20, stride = 3, mem[0x20 + 3i] = i+1 -> mem_re at 0x20, 0x23, ..., 0x35; vreg_we with data 1..8 at elem_idx 0..7; done in cycle 17.
- Masked store: mask = 8'b1010_0101, base = 0 -> mem_we only for idx 0, 2, 5, 7 at addresses 0, 2, 5, 7; done in cycle 9.
- Masked load with mask = 0 -> no mem_re and no vreg_we; done in cycle 9.
- Wrap-around: base = 0xFE, stride = 1, store -> addresses 0xFE, 0xFF, 0x00, ..., 0x05.
- Second start pulse at cycle 4 of a store -> ignored, exactly one done.
- Reset low at cycle 5 of a load -> immediately state IDLE, strobes 0, busy 0, no done.
- A new command after that reset -> executes normally.

Source files
------------

// File: rtl/vector_lsu.sv
// vector_lsu: walks VLEN elements between data memory and a vector register.
// Unit-stride, strided and masked loads/stores; one done pulse per command.
module vector_lsu #(
  parameter int VLEN = 8,
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter int IW   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            rw,
  input  logic            stride_enable,
  input  logic            mask_enable,
  input  logic [AW-1:0]   base,
  input  logic [AW-1:0]   stride,
  input  logic [VLEN-1:0] mask,
  input  logic [DW-1:0]   vreg_rdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic [IW-1:0]   elem_idx,
  output logic            vreg_we,
  output logic [DW-1:0]   vreg_wdata,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_we,
  output logic            mem_re,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CAPT,
    DONE
  } state_t;

  state_t state;
  state_t nstate;

  logic [IW-1:0]   idx;
  logic [AW-1:0]   addr;
  logic [AW-1:0]   stride_l;
  logic [VLEN-1:0] mask_l;
  logic            rw_l;
  logic            se_l;
  logic            me_l;

  logic            active;
  logic            last;
  logic            adv;
  logic            load;
  logic [AW-1:0]   step;

  assign active = ~me_l | mask_l[idx];
  assign last   = (idx == IW'(VLEN - 1));
  assign step   = se_l ? stride_l : AW'(1);

  // Next state and Moore-style strobes decoded from state and latches
  always_comb begin
    nstate     = state;
    adv        = 1'b0;
    load       = 1'b0;
    vreg_we    = 1'b0;
    vreg_wdata = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load   = 1'b1;
          nstate = RUN;
        end
      end
      RUN: begin
        if (!active) begin
          adv = 1'b1;
        end else if (rw_l) begin
          mem_we    = 1'b1;
          mem_addr  = addr;
          mem_wdata = vreg_rdata;
          adv       = 1'b1;
        end else begin
          mem_re   = 1'b1;
          mem_addr = addr;
          nstate   = CAPT;
        end
      end
      CAPT: begin
        vreg_we    = 1'b1;
        vreg_wdata = mem_rdata;
        adv        = 1'b1;
      end
      DONE: begin
        done   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
    if (adv) begin
      nstate = last ? DONE : RUN;
    end
  end

  assign busy     = (state != IDLE);
  assign elem_idx = busy ? idx : '0;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Command latch, element index and address walk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      addr     <= '0;
      stride_l <= '0;
      mask_l   <= '0;
      rw_l     <= 1'b0;
      se_l     <= 1'b0;
      me_l     <= 1'b0;
    end else if (load) begin
      idx      <= '0;
      addr     <= base;
      stride_l <= stride;
      mask_l   <= mask;
      rw_l     <= rw;
      se_l     <= stride_enable;
      me_l     <= mask_enable;
    end else if (adv) begin
      addr <= addr + step;
      if (!last) begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vector_lsu.sv
// tb_vector_lsu: directed bench for vector_lsu with memory and vreg models.
// Strobes are logged per cycle on the falling edge and compared afterwards.
module tb_vector_lsu;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic       se = 1'b0;
  logic       me = 1'b0;
  logic [7:0] base = '0;
  logic [7:0] stride = '0;
  logic [7:0] mask = '0;
  logic [7:0] vreg_rdata;
  logic [7:0] mem_rdata = '0;
  logic [2:0] elem_idx;
  logic       vreg_we;
  logic [7:0] vreg_wdata;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic       busy;
  logic       done;

  logic [7:0] mem [256];
  logic [7:0] vreg [8];

  int n_run = 0;
  int n_fail = 0;

  logic [7:0] we_a [$];
  logic [7:0] we_d [$];
  logic [7:0] re_a [$];
  logic [7:0] vw_i [$];
  logic [7:0] vw_d [$];
  int done_cyc;
  int done_cnt;
  int busy_cnt;

  vector_lsu #(
    .VLEN(8),
    .DW(8),
    .AW(8),
    .IW(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .rw(rw),
    .stride_enable(se),
    .mask_enable(me),
    .base(base),
    .stride(stride),
    .mask(mask),
    .vreg_rdata(vreg_rdata),
    .mem_rdata(mem_rdata),
    .elem_idx(elem_idx),
    .vreg_we(vreg_we),
    .vreg_wdata(vreg_wdata),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_re(mem_re),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  assign vreg_rdata = vreg[elem_idx];

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (vreg_we) vreg[elem_idx] <= vreg_wdata;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic r, input logic s, input logic m,
                     input logic [7:0] b, input logic [7:0] st,
                     input logic [7:0] mk, input int rs1,
                     input int rs2, input int rst_cyc);
    we_a.delete();
    we_d.delete();
    re_a.delete();
    vw_i.delete();
    vw_d.delete();
    done_cyc = 0;
    done_cnt = 0;
    busy_cnt = 0;
    @(negedge clk);
    rw = r;
    se = s;
    me = m;
    base = b;
    stride = st;
    mask = mk;
    start = 1'b1;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      if (rst_cyc != 0 && cyc == rst_cyc + 1) reset = 1'b1;
      if (mem_we) begin
        we_a.push_back(mem_addr);
        we_d.push_back(mem_wdata);
      end
      if (mem_re) re_a.push_back(mem_addr);
      if (vreg_we) begin
        vw_i.push_back(8'(elem_idx));
        vw_d.push_back(vreg_wdata);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (cyc == rst_cyc) begin
        #1 reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_vreg_we", vreg_we, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_done", done, 0);
        check("rst_idx", elem_idx, 0);
        check("rst_addr", mem_addr, 0);
      end
      start = (cyc == rs1 || cyc == rs2);
    end
    start = 1'b0;
  endtask

  initial begin
    int ea [4];
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) vreg[i] = '0;
    #3;
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    check("init_we", mem_we, 0);
    check("init_re", mem_re, 0);
    check("init_vwe", vreg_we, 0);
    check("init_idx", elem_idx, 0);
    check("init_addr", mem_addr, 0);
    @(negedge clk);
    reset = 1'b1;

    // unit-stride store
    for (int i = 0; i < 8; i++) vreg[i] = 8'hA0 + 8'(i);
    run(1, 0, 0, 8'h10, 8'h00, 8'h00, 0, 0, 0);
    check("us_we_cnt", we_a.size(), 8);
    for (int i = 0; i < we_a.size(); i++) begin
      check("us_addr", we_a[i], 8'h10 + 8'(i));
      check("us_data", we_d[i], 8'hA0 + 8'(i));
    end
    for (int i = 0; i < 8; i++) check("us_mem", mem[8'h10 + 8'(i)], 8'hA0 + 8'(i));
    check("us_done_cyc", done_cyc, 9);
    check("us_done_cnt", done_cnt, 1);
    check("us_busy", busy_cnt, 9);

    // strided load
    for (int i = 0; i < 8; i++) begin
      mem[8'h20 + 8'(3 * i)] = 8'(i + 1);
      vreg[i] = '0;
    end
    run(0, 1, 0, 8'h20, 8'h03, 8'h00, 0, 0, 0);
    check("sl_re_cnt", re_a.size(), 8);
    check("sl_vw_cnt", vw_i.size(), 8);
    for (int i = 0; i < re_a.size(); i++) check("sl_addr", re_a[i], 8'h20 + 8'(3 * i));
    for (int i = 0; i < vw_i.size(); i++) begin
      check("sl_idx", vw_i[i], i);
      check("sl_data", vw_d[i], i + 1);
    end
    for (int i = 0; i < 8; i++) check("sl_vreg", vreg[i], i + 1);
    check("sl_done_cyc", done_cyc, 17);
    check("sl_done_cnt", done_cnt, 1);

    // masked store
    for (int i = 0; i < 8; i++) begin
      vreg[i] = 8'hA0 + 8'(i);
      mem[i] = '0;
    end
    ea = '{0, 2, 5, 7};
    run(1, 0, 1, 8'h00, 8'h00, 8'hA5, 0, 0, 0);
    check("ms_we_cnt", we_a.size(), 4);
    for (int i = 0; i < we_a.size() && i < 4; i++) begin
      check("ms_addr", we_a[i], ea[i]);
      check("ms_data", we_d[i], 8'hA0 + 8'(ea[i]));
    end
    check("ms_done_cyc", done_cyc, 9);

    // fully masked load
    run(0, 0, 1, 8'h40, 8'h00, 8'h00, 0, 0, 0);
    check("ml_re_cnt", re_a.size(), 0);
    check("ml_vw_cnt", vw_i.size(), 0);
    check("ml_we_cnt", we_a.size(), 0);
    check("ml_done_cyc", done_cyc, 9);
    check("ml_busy", busy_cnt, 9);

    // address wrap
    run(1, 1, 0, 8'hFE, 8'h01, 8'h00, 0, 0, 0);
    check("wr_we_cnt", we_a.size(), 8);
    for (int i = 0; i < we_a.size(); i++) check("wr_addr", we_a[i], 8'(8'hFE + 8'(i)));

    // start while busy and during DONE
    run(1, 0, 0, 8'h50, 8'h00, 8'h00, 4, 9, 0);
    check("rs_done_cnt", done_cnt, 1);
    check("rs_done_cyc", done_cyc, 9);
    check("rs_we_cnt", we_a.size(), 8);
    check("rs_busy", busy_cnt, 9);

    // reset mid-load
    run(0, 0, 0, 8'h20, 8'h00, 8'h00, 0, 0, 5);
    check("rl_done_cnt", done_cnt, 0);
    check("rl_re_cnt", re_a.size(), 3);
    check("rl_vw_cnt", vw_i.size(), 2);
    check("rl_busy", busy_cnt, 5);

    // command after reset
    run(1, 0, 0, 8'h60, 8'h00, 8'h00, 0, 0, 0);
    check("ar_done_cyc", done_cyc, 9);
    check("ar_done_cnt", done_cnt, 1);
    check("ar_we_cnt", we_a.size(), 8);
    if (we_a.size() > 0) check("ar_addr0", we_a[0], 8'h60);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
